// File: rtl/anim_sequencer.sv
// ---------------------------------------------------------------------------
// anim_sequencer
// Sprite-animation sequencer for the character renderer. It holds NUM_ANIMS
// animation descriptors, plays the one selected by the movement state, and
// steps through its frames on anim_tick. Each frame has a programmable hold,
// and each animation plays either looped or one-shot. The current frame is
// mapped to a sprite-sheet row, column and width for the pattern generator.
//
// Ports:
//   clk, reset_n             system clock, asynchronous active-low reset
//   anim_tick                single-cycle advance strobe
//   anim_sel                 requested animation
//   restart / freeze         restart current animation / pause advance
//   anim_len/hold/loop       per-animation length, hold, loop flag (packed)
//   anim_row_base/width      per-animation sheet row and frame pitch (packed)
//   anim_row/col, max_width  sheet coordinates of the current frame
//   cur_anim, frame_idx      animation and frame being shown
//   frame_strobe, wrap       one-cycle pulses on frame change / loop wrap
//   anim_done                level: one-shot animation has finished
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module anim_sequencer #(
  parameter int NUM_ANIMS  = 4,
  parameter int MAX_FRAMES = 8,
  parameter int HOLD_W     = 4,
  parameter int ROW_W      = 11,
  parameter int COL_W      = 11,
  localparam int SEL_W     = (NUM_ANIMS > 1) ? $clog2(NUM_ANIMS) : 1,
  localparam int FIDX_W    = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1,
  localparam int LEN_W     = FIDX_W + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        anim_tick,
  input  logic [SEL_W-1:0]            anim_sel,
  input  logic                        restart,
  input  logic                        freeze,
  input  logic [NUM_ANIMS*LEN_W-1:0]  anim_len,
  input  logic [NUM_ANIMS*HOLD_W-1:0] anim_hold,
  input  logic [NUM_ANIMS-1:0]        anim_loop,
  input  logic [NUM_ANIMS*ROW_W-1:0]  anim_row_base,
  input  logic [NUM_ANIMS*6-1:0]      anim_width,
  output logic [ROW_W-1:0]            anim_row,
  output logic [COL_W-1:0]            anim_col,
  output logic [5:0]                  max_width,
  output logic [SEL_W-1:0]            cur_anim,
  output logic [FIDX_W-1:0]           frame_idx,
  output logic                        frame_strobe,
  output logic                        wrap,
  output logic                        anim_done
);

  localparam int PROD_W = COL_W + FIDX_W + 6;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_nxt_s;
  logic [SEL_W-1:0]    cur_nxt_s;
  logic [FIDX_W-1:0]   frame_nxt_s;
  logic                strobe_nxt_s, wrap_nxt_s;

  logic [LEN_W-1:0]    len_raw_s, len_m1_s;
  logic [HOLD_W-1:0]   hold_raw_s, hold_m1_s;
  logic                loop_s;
  logic                switch_s;

  logic [ROW_W-1:0]    row_nxt_s;
  logic [5:0]          width_nxt_s;
  logic [PROD_W-1:0]   prod_s;
  logic [COL_W-1:0]    col_nxt_s;

  // Effective L-1 and H-1 of the animation currently playing (0 treated as 1,
  // lengths beyond MAX_FRAMES clamped).
  always_comb begin
    len_raw_s  = anim_len[int'(cur_anim)*LEN_W +: LEN_W];
    hold_raw_s = anim_hold[int'(cur_anim)*HOLD_W +: HOLD_W];
    loop_s     = anim_loop[int'(cur_anim)];
    if (len_raw_s == {LEN_W{1'b0}}) begin
      len_m1_s = {LEN_W{1'b0}};
    end else if (len_raw_s > LEN_W'(MAX_FRAMES)) begin
      len_m1_s = LEN_W'(MAX_FRAMES - 1);
    end else begin
      len_m1_s = len_raw_s - LEN_W'(1);
    end
    if (hold_raw_s == {HOLD_W{1'b0}}) begin
      hold_m1_s = {HOLD_W{1'b0}};
    end else begin
      hold_m1_s = hold_raw_s - HOLD_W'(1);
    end
  end

  // Out-of-range selects (non-power-of-2 NUM_ANIMS) never cause a switch.
  assign switch_s = (anim_sel != cur_anim) &&
                    ({1'b0, anim_sel} < (SEL_W+1)'(NUM_ANIMS));

  // Next-state logic: switch > restart > freeze > tick.
  always_comb begin
    state_s      = state_r;
    hold_nxt_s   = hold_cnt_r;
    cur_nxt_s    = cur_anim;
    frame_nxt_s  = frame_idx;
    strobe_nxt_s = 1'b0;
    wrap_nxt_s   = 1'b0;
    if (switch_s || restart) begin
      if (switch_s) begin
        cur_nxt_s = anim_sel;
      end else begin
        cur_nxt_s = cur_anim;
      end
      frame_nxt_s  = {FIDX_W{1'b0}};
      hold_nxt_s   = {HOLD_W{1'b0}};
      state_s      = ST_RUN;
      strobe_nxt_s = 1'b1;
    end else if (freeze) begin
      hold_nxt_s = hold_cnt_r;
    end else if (anim_tick && (state_r == ST_RUN)) begin
      // >= comparisons keep live shrinking of len/hold safe.
      if (hold_cnt_r < hold_m1_s) begin
        hold_nxt_s = hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_nxt_s = {HOLD_W{1'b0}};
        if ({1'b0, frame_idx} < len_m1_s) begin
          frame_nxt_s  = frame_idx + FIDX_W'(1);
          strobe_nxt_s = 1'b1;
        end else if (loop_s) begin
          frame_nxt_s  = {FIDX_W{1'b0}};
          strobe_nxt_s = 1'b1;
          wrap_nxt_s   = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // Output mapping from the next-state animation and frame.
  always_comb begin
    row_nxt_s   = anim_row_base[int'(cur_nxt_s)*ROW_W +: ROW_W];
    width_nxt_s = anim_width[int'(cur_nxt_s)*6 +: 6];
    prod_s      = PROD_W'(frame_nxt_s) * PROD_W'(width_nxt_s);
    col_nxt_s   = prod_s[COL_W-1:0];
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_RUN;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      cur_anim     <= {SEL_W{1'b0}};
      frame_idx    <= {FIDX_W{1'b0}};
      frame_strobe <= 1'b0;
      wrap         <= 1'b0;
      anim_done    <= 1'b0;
      anim_row     <= {ROW_W{1'b0}};
      anim_col     <= {COL_W{1'b0}};
      max_width    <= 6'd0;
    end else begin
      state_r      <= state_s;
      hold_cnt_r   <= hold_nxt_s;
      cur_anim     <= cur_nxt_s;
      frame_idx    <= frame_nxt_s;
      frame_strobe <= strobe_nxt_s;
      wrap         <= wrap_nxt_s;
      anim_done    <= (state_s == ST_DONE);
      anim_row     <= row_nxt_s;
      anim_col     <= col_nxt_s;
      max_width    <= width_nxt_s;
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
`timescale 1ns/1ps
module tb_anim_sequencer;

  logic        clk;
  logic        reset_n;
  logic        anim_tick;
  logic [1:0]  anim_sel;
  logic        restart;
  logic        freeze;
  logic [15:0] anim_len;
  logic [15:0] anim_hold;
  logic [3:0]  anim_loop;
  logic [43:0] anim_row_base;
  logic [23:0] anim_width;
  logic [10:0] anim_row;
  logic [10:0] anim_col;
  logic [5:0]  max_width;
  logic [1:0]  cur_anim;
  logic [2:0]  frame_idx;
  logic        frame_strobe;
  logic        wrap;
  logic        anim_done;

  int checks_r;
  int failures_r;

  anim_sequencer dut (
    .clk(clk), .reset_n(reset_n), .anim_tick(anim_tick), .anim_sel(anim_sel),
    .restart(restart), .freeze(freeze), .anim_len(anim_len),
    .anim_hold(anim_hold), .anim_loop(anim_loop),
    .anim_row_base(anim_row_base), .anim_width(anim_width),
    .anim_row(anim_row), .anim_col(anim_col), .max_width(max_width),
    .cur_anim(cur_anim), .frame_idx(frame_idx), .frame_strobe(frame_strobe),
    .wrap(wrap), .anim_done(anim_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_r++;
    if (obs !== exp_v) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock edge with the given tick; outputs sampled 1 ns after the edge.
  task automatic step(input logic t);
    anim_tick = t;
    @(posedge clk);
    #1;
    anim_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row"}, 32'(anim_row), 32'd0);
    check({tag, "_col"}, 32'(anim_col), 32'd0);
    check({tag, "_width"}, 32'(max_width), 32'd0);
    check({tag, "_cur"}, 32'(cur_anim), 32'd0);
    check({tag, "_frame"}, 32'(frame_idx), 32'd0);
    check({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
    check({tag, "_wrap"}, 32'(wrap), 32'd0);
    check({tag, "_done"}, 32'(anim_done), 32'd0);
  endtask

  int exp_frame[8];

  initial begin
    checks_r   = 0;
    failures_r = 0;
    exp_frame  = '{1, 1, 2, 2, 3, 3, 0, 0};
    exp_frame  = '{0, 1, 1, 2, 2, 3, 3, 0};
    reset_n    = 1'b0;
    anim_tick  = 1'b0;
    anim_sel   = 2'd0;
    restart    = 1'b0;
    freeze     = 1'b0;
    anim_len      = {4'd0, 4'd0, 4'd3, 4'd4};
    anim_hold     = {4'd0, 4'd0, 4'd1, 4'd2};
    anim_loop     = 4'b0001;
    anim_row_base = {11'd0, 11'd0, 11'd47, 11'd0};
    anim_width    = {6'd0, 6'd0, 6'd40, 6'd46};

    // Reset state
    #23;
    check_all_zero("rst");
    reset_n = 1'b1;
    step(1'b0);
    check("first_width", 32'(max_width), 32'd46);
    check("first_frame", 32'(frame_idx), 32'd0);
    check("first_cur", 32'(cur_anim), 32'd0);
    check("first_done", 32'(anim_done), 32'd0);

    // anim0: 8 ticks, hold 2, loop over 4 frames
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      check($sformatf("a0_frame_t%0d", i + 1), 32'(frame_idx), 32'(exp_frame[i]));
      check($sformatf("a0_col_t%0d", i + 1), 32'(anim_col), 32'(exp_frame[i] * 46));
      check($sformatf("a0_strobe_t%0d", i + 1), 32'(frame_strobe), 32'(i % 2));
      check($sformatf("a0_wrap_t%0d", i + 1), 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
    end

    // Switch to anim1 (no tick)
    anim_sel = 2'd1;
    step(1'b0);
    check("sw1_cur", 32'(cur_anim), 32'd1);
    check("sw1_row", 32'(anim_row), 32'd47);
    check("sw1_width", 32'(max_width), 32'd40);
    check("sw1_strobe", 32'(frame_strobe), 32'd1);

    // anim1 one-shot: 5 ticks
    step(1'b1);
    check("a1_t1_frame", 32'(frame_idx), 32'd1);
    step(1'b1);
    check("a1_t2_frame", 32'(frame_idx), 32'd2);
    step(1'b1);
    check("a1_t3_done", 32'(anim_done), 32'd1);
    check("a1_t3_frame", 32'(frame_idx), 32'd2);
    check("a1_t3_col", 32'(anim_col), 32'd80);
    check("a1_t3_strobe", 32'(frame_strobe), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      check("a1_post_frame", 32'(frame_idx), 32'd2);
      check("a1_post_strobe", 32'(frame_strobe), 32'd0);
      check("a1_post_done", 32'(anim_done), 32'd1);
    end

    // Restart out of DONE
    restart = 1'b1;
    step(1'b0);
    restart = 1'b0;
    check("rs_done", 32'(anim_done), 32'd0);
    check("rs_frame", 32'(frame_idx), 32'd0);
    check("rs_strobe", 32'(frame_strobe), 32'd1);
    step(1'b1);
    check("rs_run_frame", 32'(frame_idx), 32'd1);

    // Back to anim0, run to frame 2, then switch with a simultaneous tick
    anim_sel = 2'd0;
    step(1'b0);
    check("sw0_cur", 32'(cur_anim), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("pre_sw_frame", 32'(frame_idx), 32'd2);
    anim_sel = 2'd1;
    step(1'b1);
    check("swt_cur", 32'(cur_anim), 32'd1);
    check("swt_frame", 32'(frame_idx), 32'd0);
    check("swt_row", 32'(anim_row), 32'd47);
    check("swt_col", 32'(anim_col), 32'd0);
    check("swt_width", 32'(max_width), 32'd40);
    check("swt_strobe", 32'(frame_strobe), 32'd1);

    // Freeze on anim1 frame 1
    step(1'b1);
    check("fz_pre_frame", 32'(frame_idx), 32'd1);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      check("fz_frame", 32'(frame_idx), 32'd1);
      check("fz_strobe", 32'(frame_strobe), 32'd0);
    end
    restart = 1'b1;
    step(1'b1);
    restart = 1'b0;
    freeze  = 1'b0;
    check("fz_rs_frame", 32'(frame_idx), 32'd0);

    // anim0 with len 0: stays on frame 0, wraps every second tick
    anim_sel = 2'd0;
    anim_len[3:0] = 4'd0;
    step(1'b0);
    step(1'b1);
    check("len0_t1_frame", 32'(frame_idx), 32'd0);
    step(1'b1);
    check("len0_t2_frame", 32'(frame_idx), 32'd0);
    check("len0_t2_wrap", 32'(wrap), 32'd1);

    // len 12 clamps to 8 frames
    anim_len[3:0] = 4'd12;
    restart = 1'b1;
    step(1'b0);
    restart = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b1);
    check("len12_frame7", 32'(frame_idx), 32'd7);
    check("len12_col7", 32'(anim_col), 32'd322);
    step(1'b1);
    step(1'b1);
    check("len12_wrap_frame", 32'(frame_idx), 32'd0);
    check("len12_wrap", 32'(wrap), 32'd1);

    // Asynchronous reset mid-play
    anim_len[3:0] = 4'd4;
    step(1'b1);
    step(1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("arst");
    #1;
    reset_n = 1'b1;
    step(1'b0);
    check("arst_rel_cur", 32'(cur_anim), 32'd0);
    check("arst_rel_frame", 32'(frame_idx), 32'd0);
    check("arst_rel_width", 32'(max_width), 32'd46);
    check("arst_rel_done", 32'(anim_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
